// File: rtl/mux_arbitro_rr.sv
`default_nettype none
// ============================================================================
// Module   : mux_arbitro_rr
// Purpose  : Two-lane buffered 2:1 mux with round-robin arbitration into a
//            single registered valid/ready output stage.
// Revision : 1.0 - initial release
// ============================================================================
module mux_arbitro_rr #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] In0,
  input  logic                  valid0,
  input  logic [DATA_WIDTH-1:0] In1,
  input  logic                  valid1,
  input  logic                  ready_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  outValid,
  output logic                  full0,
  output logic                  full1,
  output logic                  error0,
  output logic                  error1,
  output logic                  grant
);

  typedef enum logic [0:0] {
    P0 = 1'b0,
    P1 = 1'b1
  } prio_t;

  localparam logic [ADDR_WIDTH:0] c_depth = (ADDR_WIDTH + 1)'(FIFO_DEPTH);

  prio_t                 r_prio;
  logic [1:0]            w_valid;
  logic [1:0]            w_push;
  logic [1:0]            w_pop;
  logic [1:0]            w_full;
  logic [1:0]            w_nonempty;
  logic [1:0]            w_error;
  logic [DATA_WIDTH-1:0] w_in    [2];
  logic [DATA_WIDTH-1:0] w_rdata [2];
  logic                  w_can_load;
  logic                  w_load;
  logic                  w_sel;

  assign w_valid = {valid1, valid0};
  assign w_in[0] = In0;
  assign w_in[1] = In1;

  generate
    for (genvar i = 0; i < 2; i++) begin : g_lane
      logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
      logic [ADDR_WIDTH-1:0] r_wp;
      logic [ADDR_WIDTH-1:0] r_rp;
      logic [ADDR_WIDTH:0]   r_cnt;
      logic                  r_error;

      // Full comes from registered count only, so a same-cycle pop never frees a slot for a push.
      assign w_full[i]     = (r_cnt == c_depth);
      assign w_nonempty[i] = (r_cnt != '0);
      assign w_push[i]     = w_valid[i] & ~w_full[i];
      assign w_rdata[i]    = r_mem[r_rp];
      assign w_error[i]    = r_error;

      always_ff @(posedge clk) begin
        if (w_push[i]) r_mem[r_wp] <= w_in[i];
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_wp    <= '0;
          r_rp    <= '0;
          r_cnt   <= '0;
          r_error <= 1'b0;
        end else begin
          if (w_push[i]) r_wp <= r_wp + 1'b1;
          if (w_pop[i])  r_rp <= r_rp + 1'b1;
          if (w_push[i] && !w_pop[i])      r_cnt <= r_cnt + 1'b1;
          else if (!w_push[i] && w_pop[i]) r_cnt <= r_cnt - 1'b1;
          if (w_valid[i] && w_full[i]) r_error <= 1'b1;
        end
      end
    end
  endgenerate

  assign w_can_load = !outValid || ready_out;

  always_comb begin
    w_pop = 2'b00;
    if (w_can_load) begin
      if (r_prio == P0) begin
        if (w_nonempty[0])      w_pop = 2'b01;
        else if (w_nonempty[1]) w_pop = 2'b10;
      end else begin
        if (w_nonempty[1])      w_pop = 2'b10;
        else if (w_nonempty[0]) w_pop = 2'b01;
      end
    end
  end

  assign w_load = |w_pop;
  assign w_sel  = w_pop[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= '0;
      outValid <= 1'b0;
      grant    <= 1'b0;
      r_prio   <= P0;
    end else if (w_can_load) begin
      outValid <= w_load;
      if (w_load) begin
        data_out <= w_rdata[w_sel];
        grant    <= w_sel;
        r_prio   <= w_sel ? P0 : P1;
      end
    end
  end

  assign full0  = w_full[0];
  assign full1  = w_full[1];
  assign error0 = w_error[0];
  assign error1 = w_error[1];

endmodule
`default_nettype wire

// File: tb/tb_mux_arbitro_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_arbitro_rr
// Purpose  : Directed self-checking bench for mux_arbitro_rr.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_arbitro_rr;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] In0, In1;
  logic       valid0, valid1, ready_out;
  logic [7:0] data_out;
  logic       outValid, full0, full1, error0, error1, grant;

  int checks = 0;
  int errors = 0;

  mux_arbitro_rr #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .ADDR_WIDTH(2)) dut (
    .clk(clk), .reset(reset),
    .In0(In0), .valid0(valid0), .In1(In1), .valid1(valid1),
    .ready_out(ready_out),
    .data_out(data_out), .outValid(outValid),
    .full0(full0), .full1(full1), .error0(error0), .error1(error1),
    .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    valid0 = 1'b0; valid1 = 1'b0; In0 = 8'h00; In1 = 8'h00;
  endtask

  task automatic do_reset;
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    ready_out = 1'b1;
    reset = 1'b1;
    tick();
    checks++;
    if ({outValid, data_out, grant} !== {1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_out: got v=%b d=%h g=%b want v=0 d=00 g=0", outValid, data_out, grant);
    end
    checks++;
    if ({full0, full1, error0, error1} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got f0=%b f1=%b e0=%b e1=%b want all 0", full0, full1, error0, error1);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_lane;
    ready_out = 1'b1;
    for (int e = 0; e < 5; e++) begin
      valid0 = (e < 4);
      In0 = 8'(e);
      tick();
      if (e >= 1) begin
        checks++;
        if ({outValid, grant, data_out} !== {1'b1, 1'b0, 8'(e - 1)}) begin
          errors++;
          $display("FAIL single_lane[%0d]: got v=%b g=%b d=%h want v=1 g=0 d=%h",
                   e - 1, outValid, grant, data_out, 8'(e - 1));
        end
      end
    end
    idle_inputs();
    tick();
    checks++;
    if ({outValid, data_out} !== {1'b0, 8'h03}) begin
      errors++;
      $display("FAIL single_lane_idle: got v=%b d=%h want v=0 d=03", outValid, data_out);
    end
  endtask

  task automatic test_round_robin;
    logic [7:0] exp_d [8] = '{8'h00, 8'h03, 8'h01, 8'h04, 8'h02, 8'h05, 8'h03, 8'h06};
    do_reset();
    ready_out = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      valid0 = (e <= 4);
      valid1 = (e <= 4);
      In0 = 8'(e - 1);
      In1 = 8'(e + 2);
      tick();
      if (e >= 2) begin
        checks++;
        if ({outValid, grant, data_out} !== {1'b1, 1'((e - 2) % 2), exp_d[e - 2]}) begin
          errors++;
          $display("FAIL round_robin[%0d]: got v=%b g=%b d=%h want v=1 g=%0d d=%h",
                   e - 2, outValid, grant, data_out, (e - 2) % 2, exp_d[e - 2]);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_backpressure;
    do_reset();
    ready_out = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      valid0 = 1'b1;
      In0 = 8'h10 + 8'(e - 1);
      tick();
      if (e == 5) begin
        checks++;
        if ({full0, error0} !== 2'b10) begin
          errors++;
          $display("FAIL bp_full: got f0=%b e0=%b want f0=1 e0=0", full0, error0);
        end
      end
    end
    checks++;
    if ({outValid, data_out, full0, error0} !== {1'b1, 8'h10, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL bp_hold: got v=%b d=%h f0=%b e0=%b want v=1 d=10 f0=1 e0=1",
               outValid, data_out, full0, error0);
    end
    idle_inputs();
    ready_out = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ({outValid, data_out, full0, error0} !== {1'b1, 8'h11 + 8'(k), 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL bp_drain[%0d]: got v=%b d=%h f0=%b e0=%b want v=1 d=%h f0=0 e0=1",
                 k, outValid, data_out, full0, error0, 8'h11 + 8'(k));
      end
    end
  endtask

  task automatic test_idle_gap;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({outValid, data_out, error0} !== {1'b0, 8'h14, 1'b1}) begin
        errors++;
        $display("FAIL idle_gap[%0d]: got v=%b d=%h e0=%b want v=0 d=14 e0=1",
                 k, outValid, data_out, error0);
      end
    end
  endtask

  task automatic test_full_same_cycle_pop;
    do_reset();
    ready_out = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      valid1 = 1'b1;
      In1 = 8'h20 + 8'(e - 1);
      tick();
    end
    idle_inputs();
    checks++;
    if ({full1, outValid, data_out} !== {1'b1, 1'b1, 8'h20}) begin
      errors++;
      $display("FAIL fsp_fill: got f1=%b v=%b d=%h want f1=1 v=1 d=20", full1, outValid, data_out);
    end
    ready_out = 1'b1;
    valid1 = 1'b1;
    In1 = 8'hAA;
    tick();
    idle_inputs();
    checks++;
    if ({error1, full1, grant, data_out} !== {1'b1, 1'b0, 1'b1, 8'h21}) begin
      errors++;
      $display("FAIL fsp_reject: got e1=%b f1=%b g=%b d=%h want e1=1 f1=0 g=1 d=21",
               error1, full1, grant, data_out);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({outValid, data_out} !== {1'b1, 8'h22 + 8'(k)}) begin
        errors++;
        $display("FAIL fsp_drain[%0d]: got v=%b d=%h want v=1 d=%h", k, outValid, data_out, 8'h22 + 8'(k));
      end
    end
    tick();
    checks++;
    if ({outValid, data_out, error1} !== {1'b0, 8'h24, 1'b1}) begin
      errors++;
      $display("FAIL fsp_empty: got v=%b d=%h e1=%b want v=0 d=24 e1=1", outValid, data_out, error1);
    end
  endtask

  task automatic test_reset_mid_stream;
    do_reset();
    ready_out = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      valid1 = 1'b1;
      In1 = 8'h30 + 8'(e - 1);
      tick();
    end
    idle_inputs();
    checks++;
    if ({outValid, full1, grant} !== 3'b111) begin
      errors++;
      $display("FAIL mid_pre: got v=%b f1=%b g=%b want 1 1 1", outValid, full1, grant);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({outValid, data_out, full0, full1, grant} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_async: got v=%b d=%h f0=%b f1=%b g=%b want v=0 d=00 f0=0 f1=0 g=0",
               outValid, data_out, full0, full1, grant);
    end
    tick();
    reset = 1'b0;
    ready_out = 1'b1;
    valid0 = 1'b1; In0 = 8'h40;
    valid1 = 1'b1; In1 = 8'h41;
    tick();
    idle_inputs();
    tick();
    checks++;
    if ({outValid, grant, data_out} !== {1'b1, 1'b0, 8'h40}) begin
      errors++;
      $display("FAIL mid_first_grant: got v=%b g=%b d=%h want v=1 g=0 d=40", outValid, grant, data_out);
    end
    tick();
    checks++;
    if ({outValid, grant, data_out, error0, error1} !== {1'b1, 1'b1, 8'h41, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_second_grant: got v=%b g=%b d=%h e0=%b e1=%b want v=1 g=1 d=41 e0=0 e1=0",
               outValid, grant, data_out, error0, error1);
    end
  endtask

  initial begin
    reset = 1'b1;
    ready_out = 1'b1;
    idle_inputs();
    test_reset();
    test_single_lane();
    test_round_robin();
    test_backpressure();
    test_idle_gap();
    test_full_same_cycle_pop();
    test_reset_mid_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
